phase_sequence_timer: RTL and testbench
=======================================

// Module: phase_sequence_timer
// PURPOSE
//  Parametrised multi-phase down-timer for the traffic-light controller.
//  Holds a programmable duration per phase and counts them in order, using a
//  clock prescaler as the tick base. Pulses phase_done at each phase end and
//  timer_done at the end of the sequence. Optional auto-reload repeats the
//  sequence. Sits between the controller FSM and the lamp drivers.
// PARAMETERS
//  NUM_PHASES   4   number of phases in a sequence (>=1)
//  CNT_W        8   width of each phase duration and of remaining, in ticks
//  TICK_DIV     10  clk cycles per tick (>=1; 1 = tick every cycle)
//  DEFAULT_DUR  5   reset value of every phase duration register
//  AUTO_RELOAD  0   1 = wrap from last phase to phase 0 and keep running
// PORTS
//  clk          in   1                      system clock, rising edge
//  rst_n        in   1                      async active-low reset
//  start        in   1                      begin sequence at phase 0; ignored while busy
//  abort        in   1                      stop and return to IDLE; wins over start and tick
//  load_en      in   1                      write load_value into dur[load_phase]
//  load_phase   in   $clog2(NUM_PHASES)|1   target phase index (1 bit minimum)
//  load_value   in   CNT_W                  new duration in ticks
//  busy         out  1                      1 while in RUN
//  phase_idx    out  $clog2(NUM_PHASES)|1   active phase index
//  remaining    out  CNT_W                  ticks left in the active phase
//  phase_done   out  1                      1-cycle pulse at each phase end
//  timer_done   out  1                      1-cycle pulse at the end of the last phase
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE. busy, phase_idx, remaining, phase_done,
//   timer_done and the prescaler are all 0. Every dur[i] = DEFAULT_DUR.
//   Outputs clear immediately, without a clock edge.
//  FSM states: IDLE, RUN. All outputs are registered.
//  IDLE -> RUN: start=1 and abort=0 at edge E0.
//   After E0: busy=1, phase_idx=0, remaining=max(dur[0],1), prescaler=0.
//  Tick: prescaler counts 0..TICK_DIV-1 in RUN and wraps; tick = (pre==TICK_DIV-1).
//  On a tick in RUN:
//   - remaining>1: remaining decrements.
//   - remaining==1: phase_done=1 for 1 cycle.
//     - Not the last phase: phase_idx+1, remaining=max(dur[next],1).
//     - Last phase, AUTO_RELOAD=0: timer_done=1 in the same cycle. Go to IDLE:
//       busy=0, phase_idx=0, remaining=0.
//     - Last phase, AUTO_RELOAD=1: timer_done=1 in the same cycle.
//       phase_idx=0, remaining=max(dur[0],1), busy stays 1.
//  Phase i lasts max(dur[i],1)*TICK_DIV cycles.
//   A zero duration is treated as 1 tick; phases are never skipped.
//  phase_done for phase k is high in the cycle after edge
//   E0 + TICK_DIV*sum(max(dur[0..k],1)).
//  abort=1 at any edge: next state IDLE, busy/phase_idx/remaining/prescaler=0.
//   No phase_done or timer_done pulse, even on a coincident tick.
//   dur[] is retained.
//  start while busy: ignored, no restart.
//  Start in the same cycle timer_done is high (now IDLE): accepted.
//  load_en: dur[load_phase]<=load_value at the edge, in any state.
//   - A write to the active phase does not change remaining; it applies on the
//     next entry to that phase.
//   - load_phase>=NUM_PHASES: write ignored.
//   - Same-edge load and phase entry: the entering phase uses the old value.
//  Arithmetic: remaining never underflows (decrements only while >1).
//   load_value is CNT_W bits, no saturation needed.
// TESTING
//  1 NUM_PHASES=3, TICK_DIV=4, dur={2,1,3}, start at E0 ->
//    phase_done after E0+8, E0+12, E0+24.
//    timer_done and busy falling coincide with the E0+24 pulse; phase_idx 0,1,2,0.
//  2 dur[1]=0, TICK_DIV=4 -> phase 1 lasts exactly 4 cycles (1 tick), one phase_done pulse.
//  3 abort mid phase 1 -> busy=0 next cycle, no done pulses.
//    A new start reloads phase 0 with full dur[0].
//  4 AUTO_RELOAD=1, dur={1,1,1}, TICK_DIV=2 -> timer_done every 6 cycles.
//    phase_idx 2->0, busy constant 1.
//  5 load dur[0]=7 while in phase 0 -> remaining unchanged now, 7 on the next entry.
//    load_phase=3 with NUM_PHASES=3 -> no register changes.
//  6 rst_n low mid-RUN without clk edge -> outputs 0 at once.
//    After release, start runs with DEFAULT_DUR per phase.

Source files
------------

// File: rtl/phase_sequence_timer.sv
// Multi-phase down-timer: per-phase durations counted on a prescaled tick,
// with phase/sequence done pulses and optional auto-reload.
module phase_sequence_timer #(
    parameter int NUM_PHASES  = 4,
    parameter int CNT_W       = 8,
    parameter int TICK_DIV    = 10,
    parameter int DEFAULT_DUR = 5,
    parameter int AUTO_RELOAD = 0,
    localparam int PW    = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1,
    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             load_en,
    input  logic [PW-1:0]    load_phase,
    input  logic [CNT_W-1:0] load_value,
    output logic             busy,
    output logic [PW-1:0]    phase_idx,
    output logic [CNT_W-1:0] remaining,
    output logic             phase_done,
    output logic             timer_done
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [CNT_W-1:0] dur [NUM_PHASES];
    logic [PRE_W-1:0] pre;
    logic             tick;
    logic             last_phase;
    logic [PW-1:0]    next_idx;
    logic [CNT_W-1:0] next_dur;

    // A zero duration still costs one tick so no phase is ever skipped.
    function automatic logic [CNT_W-1:0] at_least_one(input logic [CNT_W-1:0] v);
        return (v == '0) ? CNT_W'(1) : v;
    endfunction

    assign tick       = (pre == PRE_W'(TICK_DIV - 1));
    assign last_phase = (phase_idx == PW'(NUM_PHASES - 1));
    assign next_idx   = last_phase ? '0 : phase_idx + 1'b1;

    // Select the duration of the phase being entered (pre-write value).
    always_comb begin
        next_dur = dur[0];
        for (int i = 0; i < NUM_PHASES; i++) begin
            if (next_idx == PW'(i)) next_dur = dur[i];
        end
    end

    // Duration register file; out-of-range indices match no entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PHASES; i++) dur[i] <= CNT_W'(DEFAULT_DUR);
        end else if (load_en) begin
            for (int i = 0; i < NUM_PHASES; i++) begin
                if (load_phase == PW'(i)) dur[i] <= load_value;
            end
        end
    end

    // Sequencer FSM with prescaler and registered outputs; abort has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            phase_idx  <= '0;
            remaining  <= '0;
            phase_done <= 1'b0;
            timer_done <= 1'b0;
            pre        <= '0;
        end else begin
            phase_done <= 1'b0;
            timer_done <= 1'b0;
            if (abort) begin
                state     <= IDLE;
                busy      <= 1'b0;
                phase_idx <= '0;
                remaining <= '0;
                pre       <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            state     <= RUN;
                            busy      <= 1'b1;
                            phase_idx <= '0;
                            remaining <= at_least_one(dur[0]);
                            pre       <= '0;
                        end
                    end
                    RUN: begin
                        pre <= tick ? '0 : pre + 1'b1;
                        if (tick) begin
                            if (remaining > CNT_W'(1)) begin
                                remaining <= remaining - 1'b1;
                            end else begin
                                phase_done <= 1'b1;
                                if (!last_phase) begin
                                    phase_idx <= next_idx;
                                    remaining <= at_least_one(next_dur);
                                end else begin
                                    timer_done <= 1'b1;
                                    if (AUTO_RELOAD != 0) begin
                                        phase_idx <= '0;
                                        remaining <= at_least_one(next_dur);
                                    end else begin
                                        state     <= IDLE;
                                        busy      <= 1'b0;
                                        phase_idx <= '0;
                                        remaining <= '0;
                                        pre       <= '0;
                                    end
                                end
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_phase_sequence_timer.sv
// Directed bench for phase_sequence_timer: one-shot instance (3 phases,
// div 4) and an auto-reload instance (3 phases, div 2).
module tb_phase_sequence_timer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, abort, load_en;
    logic [1:0] load_phase;
    logic [7:0] load_value;
    logic       busy, phase_done, timer_done;
    logic [1:0] phase_idx;
    logic [7:0] remaining;

    logic       ar_start, ar_abort, ar_load_en;
    logic [1:0] ar_load_phase;
    logic [7:0] ar_load_value;
    logic       ar_busy, ar_phase_done, ar_timer_done;
    logic [1:0] ar_phase_idx;
    logic [7:0] ar_remaining;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int pd_q[$];
    int td_q[$];

    always #5 clk = ~clk;

    phase_sequence_timer #(
        .NUM_PHASES(3), .CNT_W(8), .TICK_DIV(4),
        .DEFAULT_DUR(5), .AUTO_RELOAD(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .load_en(load_en), .load_phase(load_phase), .load_value(load_value),
        .busy(busy), .phase_idx(phase_idx), .remaining(remaining),
        .phase_done(phase_done), .timer_done(timer_done)
    );

    phase_sequence_timer #(
        .NUM_PHASES(3), .CNT_W(8), .TICK_DIV(2),
        .DEFAULT_DUR(5), .AUTO_RELOAD(1)
    ) dut_ar (
        .clk(clk), .rst_n(rst_n), .start(ar_start), .abort(ar_abort),
        .load_en(ar_load_en), .load_phase(ar_load_phase),
        .load_value(ar_load_value),
        .busy(ar_busy), .phase_idx(ar_phase_idx), .remaining(ar_remaining),
        .phase_done(ar_phase_done), .timer_done(ar_timer_done)
    );

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (phase_done) pd_q.push_back(cyc);
        if (timer_done) td_q.push_back(cyc);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic go();
        start = 1'b1;
        step();
        start = 1'b0;
        cyc = 0;
        pd_q.delete();
        td_q.delete();
    endtask

    task automatic load(input logic [1:0] p, input logic [7:0] v);
        load_en = 1'b1;
        load_phase = p;
        load_value = v;
        step();
        load_en = 1'b0;
    endtask

    task automatic stop();
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    function automatic int pdat(input int i);
        return (i < pd_q.size()) ? pd_q[i] : -1;
    endfunction

    function automatic int tdat(input int i);
        return (i < td_q.size()) ? td_q[i] : -1;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (phase_idx !== 2'd0) begin n_fail++; $display("FAIL rst_idx: got %0d want 0", phase_idx); end
        n_cmp++; if (remaining !== 8'd0) begin n_fail++; $display("FAIL rst_rem: got %0d want 0", remaining); end
        n_cmp++; if ({phase_done, timer_done} !== 2'b00) begin n_fail++; $display("FAIL rst_pulses: got %b want 00", {phase_done, timer_done}); end
        n_cmp++; if (ar_busy !== 1'b0) begin n_fail++; $display("FAIL rst_ar_busy: got %b want 0", ar_busy); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_sequence();
        load(2'd0, 8'd2);
        load(2'd1, 8'd1);
        load(2'd2, 8'd3);
        go();
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL seq_busy0: got %b want 1", busy); end
        n_cmp++; if (remaining !== 8'd2) begin n_fail++; $display("FAIL seq_rem0: got %0d want 2", remaining); end
        run(4);
        n_cmp++; if (remaining !== 8'd1) begin n_fail++; $display("FAIL seq_rem4: got %0d want 1", remaining); end
        run(4);
        n_cmp++; if (phase_idx !== 2'd1) begin n_fail++; $display("FAIL seq_idx8: got %0d want 1", phase_idx); end
        run(4);
        n_cmp++; if (phase_idx !== 2'd2) begin n_fail++; $display("FAIL seq_idx12: got %0d want 2", phase_idx); end
        n_cmp++; if (remaining !== 8'd3) begin n_fail++; $display("FAIL seq_rem12: got %0d want 3", remaining); end
        run(11);
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL seq_busy23: got %b want 1", busy); end
        run(1);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL seq_busy24: got %b want 0", busy); end
        n_cmp++; if (timer_done !== 1'b1) begin n_fail++; $display("FAIL seq_td24: got %b want 1", timer_done); end
        n_cmp++; if (phase_idx !== 2'd0) begin n_fail++; $display("FAIL seq_idx24: got %0d want 0", phase_idx); end
        n_cmp++; if (remaining !== 8'd0) begin n_fail++; $display("FAIL seq_rem24: got %0d want 0", remaining); end
        n_cmp++; if (pd_q.size() != 3) begin n_fail++; $display("FAIL seq_pd_count: got %0d want 3", pd_q.size()); end
        n_cmp++; if (pdat(0) != 8) begin n_fail++; $display("FAIL seq_pd0: got %0d want 8", pdat(0)); end
        n_cmp++; if (pdat(1) != 12) begin n_fail++; $display("FAIL seq_pd1: got %0d want 12", pdat(1)); end
        n_cmp++; if (pdat(2) != 24) begin n_fail++; $display("FAIL seq_pd2: got %0d want 24", pdat(2)); end
        n_cmp++; if (td_q.size() != 1) begin n_fail++; $display("FAIL seq_td_count: got %0d want 1", td_q.size()); end
        start = 1'b1;
        step();
        start = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL seq_restart_busy: got %b want 1", busy); end
        n_cmp++; if (remaining !== 8'd2) begin n_fail++; $display("FAIL seq_restart_rem: got %0d want 2", remaining); end
        stop();
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL seq_stop: got %b want 0", busy); end
    endtask

    task automatic test_zero_dur();
        load(2'd1, 8'd0);
        go();
        run(8);
        n_cmp++; if (phase_idx !== 2'd1) begin n_fail++; $display("FAIL zd_idx: got %0d want 1", phase_idx); end
        n_cmp++; if (remaining !== 8'd1) begin n_fail++; $display("FAIL zd_rem: got %0d want 1", remaining); end
        run(16);
        n_cmp++; if (pd_q.size() != 3) begin n_fail++; $display("FAIL zd_pd_count: got %0d want 3", pd_q.size()); end
        n_cmp++; if (pdat(1) != 12) begin n_fail++; $display("FAIL zd_pd1: got %0d want 12", pdat(1)); end
        n_cmp++; if (pdat(2) != 24) begin n_fail++; $display("FAIL zd_pd2: got %0d want 24", pdat(2)); end
        load(2'd1, 8'd1);
    endtask

    task automatic test_abort();
        go();
        run(11);
        abort = 1'b1;
        step();
        abort = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ab_busy: got %b want 0", busy); end
        n_cmp++; if (phase_done !== 1'b0) begin n_fail++; $display("FAIL ab_pd: got %b want 0", phase_done); end
        n_cmp++; if (remaining !== 8'd0) begin n_fail++; $display("FAIL ab_rem: got %0d want 0", remaining); end
        run(15);
        n_cmp++; if (pd_q.size() != 1) begin n_fail++; $display("FAIL ab_pd_count: got %0d want 1", pd_q.size()); end
        n_cmp++; if (td_q.size() != 0) begin n_fail++; $display("FAIL ab_td_count: got %0d want 0", td_q.size()); end
        go();
        n_cmp++; if (remaining !== 8'd2) begin n_fail++; $display("FAIL ab_reload_rem: got %0d want 2", remaining); end
        run(3);
        start = 1'b1;
        step();
        start = 1'b0;
        n_cmp++; if (remaining !== 8'd1) begin n_fail++; $display("FAIL ab_busy_start_rem: got %0d want 1", remaining); end
        run(4);
        n_cmp++; if (pdat(0) != 8) begin n_fail++; $display("FAIL ab_busy_start_pd: got %0d want 8", pdat(0)); end
        stop();
    endtask

    task automatic test_auto_reload();
        int td_cnt = 0;
        int td_bad = 0;
        int busy_low = 0;
        logic [1:0] idx5 = 2'd3;
        logic [1:0] idx6 = 2'd3;
        ar_load_en = 1'b1;
        for (int p = 0; p < 3; p++) begin
            ar_load_phase = 2'(p);
            ar_load_value = 8'd1;
            step();
        end
        ar_load_en = 1'b0;
        ar_start = 1'b1;
        step();
        ar_start = 1'b0;
        for (int n = 1; n <= 18; n++) begin
            step();
            if (ar_timer_done) begin
                td_cnt++;
                if (n % 6 != 0) td_bad++;
            end
            if (!ar_busy) busy_low++;
            if (n == 5) idx5 = ar_phase_idx;
            if (n == 6) idx6 = ar_phase_idx;
        end
        n_cmp++; if (td_cnt != 3) begin n_fail++; $display("FAIL ar_td_count: got %0d want 3", td_cnt); end
        n_cmp++; if (td_bad != 0) begin n_fail++; $display("FAIL ar_td_period: got %0d off-period want 0", td_bad); end
        n_cmp++; if (busy_low != 0) begin n_fail++; $display("FAIL ar_busy: got %0d low cycles want 0", busy_low); end
        n_cmp++; if (idx5 !== 2'd2) begin n_fail++; $display("FAIL ar_idx5: got %0d want 2", idx5); end
        n_cmp++; if (idx6 !== 2'd0) begin n_fail++; $display("FAIL ar_idx6: got %0d want 0", idx6); end
        ar_abort = 1'b1;
        step();
        ar_abort = 1'b0;
        n_cmp++; if (ar_busy !== 1'b0) begin n_fail++; $display("FAIL ar_abort: got %b want 0", ar_busy); end
    endtask

    task automatic test_load();
        go();
        run(1);
        load_en = 1'b1;
        load_phase = 2'd0;
        load_value = 8'd7;
        step();
        load_en = 1'b0;
        n_cmp++; if (remaining !== 8'd2) begin n_fail++; $display("FAIL ld_active_rem: got %0d want 2", remaining); end
        run(2);
        n_cmp++; if (remaining !== 8'd1) begin n_fail++; $display("FAIL ld_active_rem4: got %0d want 1", remaining); end
        run(20);
        n_cmp++; if (tdat(0) != 24) begin n_fail++; $display("FAIL ld_td: got %0d want 24", tdat(0)); end
        go();
        n_cmp++; if (remaining !== 8'd7) begin n_fail++; $display("FAIL ld_next_entry: got %0d want 7", remaining); end
        stop();
        load(2'd3, 8'd9);
        start = 1'b1;
        load_en = 1'b1;
        load_phase = 2'd0;
        load_value = 8'd9;
        step();
        start = 1'b0;
        load_en = 1'b0;
        cyc = 0;
        pd_q.delete();
        td_q.delete();
        n_cmp++; if (remaining !== 8'd7) begin n_fail++; $display("FAIL ld_same_edge: got %0d want 7", remaining); end
        run(44);
        n_cmp++; if (pdat(0) != 28) begin n_fail++; $display("FAIL ld_oor_pd0: got %0d want 28", pdat(0)); end
        n_cmp++; if (pdat(1) != 32) begin n_fail++; $display("FAIL ld_oor_pd1: got %0d want 32", pdat(1)); end
        n_cmp++; if (pdat(2) != 44) begin n_fail++; $display("FAIL ld_oor_pd2: got %0d want 44", pdat(2)); end
        go();
        n_cmp++; if (remaining !== 8'd9) begin n_fail++; $display("FAIL ld_after_same_edge: got %0d want 9", remaining); end
        stop();
    endtask

    task automatic test_reset_midrun();
        go();
        run(5);
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mr_busy: got %b want 0", busy); end
        n_cmp++; if (remaining !== 8'd0) begin n_fail++; $display("FAIL mr_rem: got %0d want 0", remaining); end
        n_cmp++; if (phase_idx !== 2'd0) begin n_fail++; $display("FAIL mr_idx: got %0d want 0", phase_idx); end
        #2;
        rst_n = 1'b1;
        step();
        go();
        n_cmp++; if (remaining !== 8'd5) begin n_fail++; $display("FAIL mr_default_rem: got %0d want 5", remaining); end
        run(20);
        n_cmp++; if (pdat(0) != 20) begin n_fail++; $display("FAIL mr_default_pd: got %0d want 20", pdat(0)); end
        n_cmp++; if (phase_idx !== 2'd1) begin n_fail++; $display("FAIL mr_idx20: got %0d want 1", phase_idx); end
        n_cmp++; if (remaining !== 8'd5) begin n_fail++; $display("FAIL mr_rem20: got %0d want 5", remaining); end
        stop();
    endtask

    initial begin
        start = 1'b0;
        abort = 1'b0;
        load_en = 1'b0;
        load_phase = 2'd0;
        load_value = 8'd0;
        ar_start = 1'b0;
        ar_abort = 1'b0;
        ar_load_en = 1'b0;
        ar_load_phase = 2'd0;
        ar_load_value = 8'd0;
        test_reset();
        test_sequence();
        test_zero_dur();
        test_abort();
        test_auto_reload();
        test_load();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
